rvee_alu_issue: RTL and testbench
=================================

RVEE_ALU_ISSUE -- requirements
Module: rvee_alu_issue

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have one clock, clk, and reset rst_n, asynchronous, active-low.
- clk  input  1  clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have the following ports:
- flush  input  1  synchronous pipeline kill.
- in_valid  input  1  decoded OP/OP-IMM instruction present.
- in_ready  output  1  instruction accepted this cycle when in_valid is also high.
- in_funct3  input  3  RV32I funct3.
- in_funct7_5  input  1  instruction bit 30.
- in_is_imm  input  1  1 selects OP-IMM (second operand in_imm), 0 selects OP (in_rs2).
- in_rs1  input  XLEN  first operand value.
- in_rs2  input  XLEN  second register operand value.
- in_imm  input  XLEN  sign-extended immediate.
- in_rd  input  5  destination register index.
- out_valid  output  1  result present.
- out_ready  input  1  writeback accepts the result.
- out_rd  output  5  destination index of the result.
- out_data  output  XLEN  result.
- alu_if  rvee_alu_if initiator port: drives a, b, c, op, msb_xor, sra; samples d.

Function
REQ-004 SHALL be a two-stage elastic pipeline: S1 is the operand register that drives alu_if; S2 is the result register that drives out_*.
REQ-005 SHALL transfer on input when in_valid && in_ready at a rising edge; on output when out_valid && out_ready at a rising edge.
REQ-006 SHALL compute s1_adv = !s2_valid || out_ready and in_ready = !flush && (!s1_valid || s1_adv); the out_ready-to-in_ready combinational path is permitted.
REQ-007 SHALL, with no backpressure, assert out_valid in the cycle after the S1 cycle, i.e. two cycles after the accepting edge; throughput is one instruction per cycle.
REQ-008 SHALL, when S1 advances into S2 and a new input is accepted at the same edge, load both stages with no bubble.
REQ-009 SHALL hold out_data/out_rd stable while out_valid && !out_ready.
REQ-010 SHALL preserve order and SHALL never drop or duplicate an instruction.
REQ-011 SHALL register operand conditioning at S1 load, with opnd = in_is_imm ? in_imm : in_rs2:
- op = ALU_* encoding for funct3: 0 ADD, 1 SLL, 2 SLT, 3 SLTU, 4 XOR, 5 SRL, 6 OR, 7 AND.
- a = in_rs1.
- For SUB (funct3=0, !in_is_imm, funct7_5=1), SLT and SLTU: b = ~opnd, c = 1.
- For all other operations: b = opnd, c = 0.
- msb_xor = in_rs1[XLEN-1] ^ opnd[XLEN-1] (uninverted operand).
- sra = (funct3==5) && in_funct7_5, for both OP and OP-IMM.
REQ-012 SHALL ignore in_funct7_5 for ADDI; there is no immediate subtract.
REQ-013 SHALL capture alu_if.d into out_data, and the S1 rd into out_rd, when S1 advances.
REQ-014 SHALL deliver results for rd=0 unchanged; discarding them is left to writeback.
REQ-015 SHALL, on flush high at an edge, clear s1_valid and s2_valid, accept no input, and take priority over all transfers.
REQ-016 SHALL keep data registers unchanged when their stage does not load; data registers need not be reset.

Reset
REQ-017 SHALL, while rst_n is low, force s1_valid=0 and s2_valid=0 immediately, without a clock, so out_valid=0.
REQ-018 SHALL have in_ready=1 from the first cycle after reset release (flush low).
REQ-019 SHALL abort any in-flight instruction on reset mid-operation and SHALL produce no output for it.

Verification
REQ-020 SHALL pass: both stages full, rst_n pulsed low between edges -> out_valid=0 asynchronously; after release in_ready=1 and no stale output.
REQ-021 SHALL pass: SUB rs1=5, rs2=7, out_ready=1 -> out_data=0xFFFFFFFE with out_valid two cycles after accept.
REQ-022 SHALL pass: SLT rs1=0xFFFFFFFF, rs2=1 -> 1; SLTU with the same operands -> 0; SLTI rs1=3, imm=3 -> 0.
REQ-023 SHALL pass: SRAI rs1=0x80000000, shamt 4 (funct7_5=1) -> 0xF8000000; SRLI -> 0x08000000; SLL rs1=1, rs2=0x21 -> 0x00000002.
REQ-024 SHALL pass: out_ready held low, three back-to-back ops -> two accepted, then in_ready=0; on out_ready=1, results emerge in order one per cycle and the third is accepted the same cycle.
REQ-025 SHALL pass: flush with both stages full and in_valid=1 -> next cycle out_valid=0, input not accepted, and no flushed result ever appears.

Source files
------------

// File: rtl/rvee_alu_issue_if.sv
// Operand/result handshake between the issue pipeline and the combinational ALU.
// op encoding: 0 ADD, 1 SLL, 2 SLT, 3 SLTU, 4 XOR, 5 SRL/SRA, 6 OR, 7 AND.
interface rvee_alu_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            c;
  logic [2:0]      op;
  logic            msb_xor;
  logic            sra;
  logic [XLEN-1:0] d;

  modport initiator (output a, b, c, op, msb_xor, sra, input d);
  modport target    (input a, b, c, op, msb_xor, sra, output d);
endinterface

// File: rtl/rvee_alu_issue.sv
// Two-stage elastic issue pipeline for RV32I OP/OP-IMM: S1 holds conditioned ALU
// operands driving alu_if, S2 captures the ALU result for writeback.
module rvee_alu_issue #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_funct3,
  input  logic            in_funct7_5,
  input  logic            in_is_imm,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [XLEN-1:0] in_imm,
  input  logic [4:0]      in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_data,
  rvee_alu_if.initiator   alu_if
);

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            c;
    logic [2:0]      op;
    logic            msb_xor;
    logic            sra;
    logic [4:0]      rd;
  } s1_t;

  logic            s1_valid_q, s1_valid_d;
  logic            s2_valid_q, s2_valid_d;
  s1_t             s1_q, s1_d;
  logic [XLEN-1:0] out_data_q, out_data_d;
  logic [4:0]      out_rd_q, out_rd_d;
  logic            s1_adv, s1_load, s2_load;
  logic [XLEN-1:0] opnd;
  logic            inv_b;

  assign s1_adv   = !s2_valid_q || out_ready;
  assign in_ready = !flush && (!s1_valid_q || s1_adv);
  assign s1_load  = in_valid && in_ready;
  assign s2_load  = !flush && s1_valid_q && s1_adv;

  // SUB/SLT/SLTU all run through the adder as a + ~b + 1; funct3 maps 1:1 onto op.
  always_comb begin
    opnd  = in_is_imm ? in_imm : in_rs2;
    inv_b = (in_funct3 == 3'd0 && !in_is_imm && in_funct7_5) ||
            (in_funct3 == 3'd2) || (in_funct3 == 3'd3);
    s1_d  = s1_q;
    if (s1_load) begin
      s1_d.a       = in_rs1;
      s1_d.b       = inv_b ? ~opnd : opnd;
      s1_d.c       = inv_b;
      s1_d.op      = in_funct3;
      s1_d.msb_xor = in_rs1[XLEN-1] ^ opnd[XLEN-1];
      s1_d.sra     = (in_funct3 == 3'd5) && in_funct7_5;
      s1_d.rd      = in_rd;
    end
  end

  always_comb begin
    out_data_d = out_data_q;
    out_rd_d   = out_rd_q;
    if (s2_load) begin
      out_data_d = alu_if.d;
      out_rd_d   = s1_q.rd;
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      if (s2_load)        s2_valid_d = 1'b1;
      else if (out_ready) s2_valid_d = 1'b0;
      if (s1_load)        s1_valid_d = 1'b1;
      else if (s2_load)   s1_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
    end
  end

  // Payload flops carry no reset; the valid bits qualify them.
  always_ff @(posedge clk) begin
    s1_q       <= s1_d;
    out_data_q <= out_data_d;
    out_rd_q   <= out_rd_d;
  end

  assign alu_if.a       = s1_q.a;
  assign alu_if.b       = s1_q.b;
  assign alu_if.c       = s1_q.c;
  assign alu_if.op      = s1_q.op;
  assign alu_if.msb_xor = s1_q.msb_xor;
  assign alu_if.sra     = s1_q.sra;

  assign out_valid = s2_valid_q;
  assign out_data  = out_data_q;
  assign out_rd    = out_rd_q;

endmodule

// File: tb/tb_rvee_alu_issue.sv
// Directed bench for rvee_alu_issue; a behavioural ALU answers on the alu_if target side.
module tb_rvee_alu_issue;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [2:0]      in_funct3 = '0;
  logic            in_funct7_5 = 1'b0;
  logic            in_is_imm = 1'b0;
  logic [XLEN-1:0] in_rs1 = '0;
  logic [XLEN-1:0] in_rs2 = '0;
  logic [XLEN-1:0] in_imm = '0;
  logic [4:0]      in_rd = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [4:0]      out_rd;
  logic [XLEN-1:0] out_data;

  int checks = 0;
  int errors = 0;

  rvee_alu_if #(.XLEN(XLEN)) alu_bus ();

  rvee_alu_issue #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_funct3(in_funct3), .in_funct7_5(in_funct7_5), .in_is_imm(in_is_imm),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rd(out_rd), .out_data(out_data),
    .alu_if(alu_bus)
  );

  always #5 clk = ~clk;

  // Reference ALU: adder-based compares, shifts on b[4:0].
  logic [XLEN:0] alu_sum;
  always_comb begin
    alu_sum   = {1'b0, alu_bus.a} + {1'b0, alu_bus.b} + {{XLEN{1'b0}}, alu_bus.c};
    alu_bus.d = '0;
    case (alu_bus.op)
      3'd0: alu_bus.d = alu_sum[XLEN-1:0];
      3'd1: alu_bus.d = alu_bus.a << alu_bus.b[4:0];
      3'd2: alu_bus.d = {{(XLEN-1){1'b0}}, alu_bus.msb_xor ? alu_bus.a[XLEN-1] : alu_sum[XLEN-1]};
      3'd3: alu_bus.d = {{(XLEN-1){1'b0}}, ~alu_sum[XLEN]};
      3'd4: alu_bus.d = alu_bus.a ^ alu_bus.b;
      3'd5: alu_bus.d = alu_bus.sra ? XLEN'($signed(alu_bus.a) >>> alu_bus.b[4:0])
                                    : alu_bus.a >> alu_bus.b[4:0];
      3'd6: alu_bus.d = alu_bus.a | alu_bus.b;
      default: alu_bus.d = alu_bus.a & alu_bus.b;
    endcase
  end

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change 1ns after it, checks happen 2ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] f3, input logic f75, input logic imm_sel,
                       input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] rs2,
                       input logic [XLEN-1:0] imm, input logic [4:0] rd);
    in_valid = 1'b1; in_funct3 = f3; in_funct7_5 = f75; in_is_imm = imm_sel;
    in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_rd = rd;
  endtask

  task automatic run_op(input string tag, input logic [2:0] f3, input logic f75,
                        input logic imm_sel, input logic [XLEN-1:0] rs1,
                        input logic [XLEN-1:0] rs2, input logic [XLEN-1:0] imm,
                        input logic [4:0] rd, input logic [XLEN-1:0] exp);
    out_ready = 1'b1;
    drive(f3, f75, imm_sel, rs1, rs2, imm, rd);
    #1 chk({tag, ".in_ready"}, XLEN'(in_ready), 1);
    step();
    in_valid = 1'b0;
    #1 chk({tag, ".s1_cycle_valid"}, XLEN'(out_valid), 0);
    step();
    #1;
    chk({tag, ".out_valid"}, XLEN'(out_valid), 1);
    chk({tag, ".out_data"}, out_data, exp);
    chk({tag, ".out_rd"}, XLEN'(out_rd), XLEN'(rd));
    step();
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst.out_valid", XLEN'(out_valid), 0);
    step(); step();
    rst_n = 1'b1;
    step();
    #1 chk("rst.in_ready", XLEN'(in_ready), 1);
    chk("rst.no_output", XLEN'(out_valid), 0);

    // Single ops, no backpressure
    run_op("sub",   3'd0, 1'b1, 1'b0, 32'd5,          32'd7,  32'd0,          5'd3,  32'hFFFF_FFFE);
    run_op("slt",   3'd2, 1'b0, 1'b0, 32'hFFFF_FFFF,  32'd1,  32'd0,          5'd4,  32'd1);
    run_op("sltu",  3'd3, 1'b0, 1'b0, 32'hFFFF_FFFF,  32'd1,  32'd0,          5'd5,  32'd0);
    run_op("slti",  3'd2, 1'b0, 1'b1, 32'd3,          32'd99, 32'd3,          5'd6,  32'd0);
    run_op("srai",  3'd5, 1'b1, 1'b1, 32'h8000_0000,  32'd0,  32'h0000_0404,  5'd7,  32'hF800_0000);
    run_op("srli",  3'd5, 1'b0, 1'b1, 32'h8000_0000,  32'd0,  32'd4,          5'd8,  32'h0800_0000);
    run_op("sll",   3'd1, 1'b0, 1'b0, 32'd1,          32'h21, 32'd0,          5'd9,  32'd2);
    run_op("addi_f75", 3'd0, 1'b1, 1'b1, 32'd10,      32'd0,  32'hFFFF_FFFF,  5'd10, 32'd9);
    run_op("add",   3'd0, 1'b0, 1'b0, 32'h7FFF_FFFF,  32'd1,  32'd0,          5'd11, 32'h8000_0000);
    run_op("xor",   3'd4, 1'b0, 1'b0, 32'h0000_F0F0,  32'h0000_FF00, 32'd0,   5'd12, 32'h0000_0FF0);
    run_op("ori",   3'd6, 1'b0, 1'b1, 32'h0000_F0F0,  32'd0,  32'h0000_FF00,  5'd13, 32'h0000_FFF0);
    run_op("and",   3'd7, 1'b0, 1'b0, 32'h0000_F0F0,  32'h0000_FF00, 32'd0,   5'd14, 32'h0000_F000);
    run_op("rd0",   3'd0, 1'b0, 1'b1, 32'd20,         32'd0,  32'd22,         5'd0,  32'd42);

    // Backpressure: two accepted, third stalls, then drains in order
    out_ready = 1'b0;
    drive(3'd0, 1'b0, 1'b0, 32'd1, 32'd1, 32'd0, 5'd1);
    #1 chk("bp.acc_a", XLEN'(in_ready), 1);
    step();
    drive(3'd0, 1'b0, 1'b0, 32'd2, 32'd2, 32'd0, 5'd2);
    #1 chk("bp.acc_b", XLEN'(in_ready), 1);
    step();
    drive(3'd0, 1'b0, 1'b0, 32'd3, 32'd3, 32'd0, 5'd3);
    #1 chk("bp.stall_c", XLEN'(in_ready), 0);
    chk("bp.a_valid", XLEN'(out_valid), 1);
    chk("bp.a_data", out_data, 32'd2);
    step();
    #1 chk("bp.hold_data", out_data, 32'd2);
    chk("bp.hold_rd", XLEN'(out_rd), 1);
    chk("bp.still_stall", XLEN'(in_ready), 0);
    out_ready = 1'b1;
    #1 chk("bp.release_ready", XLEN'(in_ready), 1);
    step();
    in_valid = 1'b0;
    #1 chk("bp.b_valid", XLEN'(out_valid), 1);
    chk("bp.b_data", out_data, 32'd4);
    chk("bp.b_rd", XLEN'(out_rd), 2);
    step();
    #1 chk("bp.c_valid", XLEN'(out_valid), 1);
    chk("bp.c_data", out_data, 32'd6);
    chk("bp.c_rd", XLEN'(out_rd), 3);
    step();
    #1 chk("bp.drained", XLEN'(out_valid), 0);

    // Flush with both stages full and a pending input
    out_ready = 1'b0;
    drive(3'd0, 1'b0, 1'b1, 32'd100, 32'd0, 32'd1, 5'd20);
    step();
    drive(3'd0, 1'b0, 1'b1, 32'd200, 32'd0, 32'd1, 5'd21);
    step();
    drive(3'd0, 1'b0, 1'b1, 32'd300, 32'd0, 32'd1, 5'd22);
    flush = 1'b1;
    #1 chk("fl.in_ready", XLEN'(in_ready), 0);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1 chk("fl.out_valid", XLEN'(out_valid), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      #1 chk("fl.no_stale", XLEN'(out_valid), 0);
    end

    // Asynchronous reset mid-flight
    out_ready = 1'b0;
    drive(3'd0, 1'b0, 1'b1, 32'd7, 32'd0, 32'd1, 5'd25);
    step();
    drive(3'd0, 1'b0, 1'b1, 32'd8, 32'd0, 32'd1, 5'd26);
    step();
    in_valid = 1'b0;
    #1 chk("ar.full", XLEN'(out_valid), 1);
    #1 rst_n = 1'b0;
    #1 chk("ar.async_clear", XLEN'(out_valid), 0);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1 chk("ar.in_ready", XLEN'(in_ready), 1);
    for (int i = 0; i < 3; i++) begin
      step();
      #1 chk("ar.no_stale", XLEN'(out_valid), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
